btn_sw_input_conditioner: RTL and testbench

Input-side front end for the board's user controls: turns raw, asynchronous, bouncing BTN and SW pins into clean, clock-synchronous signals for the core logic that drives the 7-segment display.
- Per button: 2-flop synchronizer, counter-based debouncer, and one-cycle press/release strobes.
- Per switch: 2-flop synchronizer only.
- Sits directly behind the top-level BTN/SW pins, in front of all consumer logic.

---
 rtl/btn_sw_input_conditioner.sv | 82 ++++++++
 tb/tb_btn_sw_input_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_sw_input_conditioner.sv
// Front end for the board's buttons and switches: brings the raw, bouncing,
// asynchronous pins into the clk domain. Buttons are debounced and also
// produce one-cycle press and release strobes. Switches are only synchronized.
module btn_sw_input_conditioner #(
    parameter int N_BTN           = 5,
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] BTN,
    input  logic [N_SW-1:0]  SW,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_sync
);

    // Terminal count. The change is accepted on the edge at which the
    // counter already holds this value, which is DEBOUNCE_CYCLES edges of
    // continuous disagreement.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] r_btn_s1;
    logic [N_BTN-1:0] r_btn_s2;
    logic [N_SW-1:0]  r_sw_s1;
    logic [N_SW-1:0]  r_sw_s2;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;

    // Two-flop synchronizers for every button and switch pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= BTN;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= SW;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Per-button debouncer. Any return to agreement restarts the count,
    // so bounce delays acceptance and never adds up toward it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_btn_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i]   <= r_btn_s2[i];
                    r_press[i]   <= r_btn_s2[i];
                    r_release[i] <= ~r_btn_s2[i];
                    r_cnt[i]     <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign sw_sync     = r_sw_s2;

endmodule

// File: tb/tb_btn_sw_input_conditioner.sv
// Bench for btn_sw_input_conditioner with DEBOUNCE_CYCLES = 4. The directed
// scenarios check against hand-derived edge numbers. The random phase checks
// against a run-length model.
module tb_btn_sw_input_conditioner;

    localparam int NB = 5;
    localparam int NS = 16;
    localparam int D  = 4;

    logic          clk;
    logic          reset;
    logic [NB-1:0] BTN;
    logic [NS-1:0] SW;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NS-1:0] sw_sync;

    int tests_run    = 0;
    int tests_failed = 0;

    btn_sw_input_conditioner #(
        .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(D), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .BTN(BTN), .SW(SW),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .sw_sync(sw_sync)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model. Each pin reaches the debouncer two edges late.
    // A button's level flips once that delayed pin has disagreed with the
    // level for D consecutive edges.
    logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_level = '0, m_press = '0, m_release = '0;
    logic [NS-1:0] m_sw1 = '0, m_sw2 = '0;
    int            m_run [NB];

    initial begin
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0;
                m_sw1 = '0; m_sw2 = '0;
                for (int i = 0; i < NB; i++) m_run[i] = 0;
            end else begin
                m_press = '0;
                m_release = '0;
                for (int i = 0; i < NB; i++) begin
                    if (m_d2[i] != m_level[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == D) begin
                            m_level[i] = m_d2[i];
                            if (m_d2[i]) m_press[i] = 1'b1;
                            else         m_release[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_d2 = m_d1;  m_d1 = BTN;
                m_sw2 = m_sw1; m_sw1 = SW;
            end
        end
    end

    task automatic idle(input int n);
        BTN = '0;
        SW  = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        BTN = '0;
        SW  = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({btn_level, btn_press, btn_release, sw_sync} !== 31'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h required 0", {btn_level, btn_press, btn_release, sw_sync});
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release, sw_sync} !== 31'd0) begin
                tests_failed++;
                $display("FAIL reset_after k=%0d: got %h required 0", k, {btn_level, btn_press, btn_release, sw_sync});
            end
        end
    endtask

    task automatic test_clean_press;
        logic [NB-1:0] el, ep, er;
        BTN[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            el = (k >= 5) ? 5'b00100 : 5'b00000;
            ep = (k == 5) ? 5'b00100 : 5'b00000;
            tests_run++;
            if ({btn_level, btn_press, btn_release} !== {el, ep, 5'b00000}) begin
                tests_failed++;
                $display("FAIL clean_press k=%0d: got lvl=%b prs=%b rel=%b required lvl=%b prs=%b rel=00000",
                         k, btn_level, btn_press, btn_release, el, ep);
            end
        end
        BTN[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            el = (k >= 5) ? 5'b00000 : 5'b00100;
            er = (k == 5) ? 5'b00100 : 5'b00000;
            tests_run++;
            if ({btn_level, btn_press, btn_release} !== {el, 5'b00000, er}) begin
                tests_failed++;
                $display("FAIL clean_release k=%0d: got lvl=%b prs=%b rel=%b required lvl=%b prs=00000 rel=%b",
                         k, btn_level, btn_press, btn_release, el, er);
            end
        end
        idle(4);
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        int npress;
        pat = 5'b10101;
        npress = 0;
        for (int k = 0; k < 25; k++) begin
            BTN[3] = (k < 5) ? pat[k] : 1'b1;
            @(negedge clk);
            if (btn_press[3]) npress++;
            tests_run++;
            if (btn_press[3] !== (k == 9) || btn_level[3] !== (k >= 9)) begin
                tests_failed++;
                $display("FAIL bounce k=%0d: got prs3=%b lvl3=%b required prs3=%b lvl3=%b",
                         k, btn_press[3], btn_level[3], (k == 9), (k >= 9));
            end
        end
        tests_run++;
        if (npress != 1) begin
            tests_failed++;
            $display("FAIL bounce_count: got %0d presses required 1", npress);
        end
        idle(12);
    endtask

    task automatic test_glitch;
        for (int k = 0; k < 15; k++) begin
            BTN[0] = (k < 3);
            @(negedge clk);
            tests_run++;
            if ({btn_level[0], btn_press[0], btn_release[0]} !== 3'b000) begin
                tests_failed++;
                $display("FAIL glitch k=%0d: got lvl/prs/rel=%b required 000",
                         k, {btn_level[0], btn_press[0], btn_release[0]});
            end
        end
        idle(4);
    endtask

    task automatic test_simultaneous;
        logic [NS-1:0] es;
        logic [NB-1:0] ep;
        BTN = 5'b10001;
        SW  = 16'h000D;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            es = (k >= 1) ? 16'h000D : 16'h0000;
            ep = (k == 5) ? 5'b10001 : 5'b00000;
            tests_run++;
            if (sw_sync !== es || btn_press !== ep) begin
                tests_failed++;
                $display("FAIL simultaneous k=%0d: got sw=%h prs=%b required sw=%h prs=%b",
                         k, sw_sync, btn_press, es, ep);
            end
        end
        idle(12);
    endtask

    task automatic test_reset_mid_count;
        logic [NB-1:0] ep;
        BTN[1] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            reset = (k == 4);
            @(negedge clk);
            if (k == 4) begin
                tests_run++;
                if ({btn_level, btn_press, btn_release} !== 15'd0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_clear: got %b required 0", {btn_level, btn_press, btn_release});
                end
            end
            ep = (k == 10) ? 5'b00010 : 5'b00000;
            tests_run++;
            if (btn_press !== ep || btn_level[1] !== (k >= 10)) begin
                tests_failed++;
                $display("FAIL reset_mid k=%0d: got prs=%b lvl1=%b required prs=%b lvl1=%b",
                         k, btn_press, btn_level[1], ep, (k >= 10));
            end
        end
        reset = 1'b0;
        idle(12);
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 5) == 0) BTN[i] = ~BTN[i];
            if ($urandom_range(0, 2) == 0) SW = NS'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            tests_run++;
            if ({btn_level, btn_press, btn_release, sw_sync} !== {m_level, m_press, m_release, m_sw2}) begin
                tests_failed++;
                $display("FAIL random c=%0d: got lvl=%b prs=%b rel=%b sw=%h required lvl=%b prs=%b rel=%b sw=%h",
                         c, btn_level, btn_press, btn_release, sw_sync, m_level, m_press, m_release, m_sw2);
            end
            tests_run++;
            if ((btn_press & btn_release) !== 5'b00000) begin
                tests_failed++;
                $display("FAIL random_exclusive c=%0d: got prs&rel=%b required 00000", c, btn_press & btn_release);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        BTN   = '0;
        SW    = '0;
        @(negedge clk);
        test_reset;
        test_clean_press;
        test_bounce;
        test_glitch;
        test_simultaneous;
        test_reset_mid_count;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
